// File: rtl/cordic_sincos_pkg.sv
// Shared definitions for the cordic_sincos block: Q18 angle constants,
// the arctangent table used by the micro-rotations and the FSM state type.
package cordic_pkg;

   // Q18 angle constants (1.0 rad = 262144)
   localparam int PI      = 32'sd823550;
   localparam int HALF_PI = 32'sd411775;
   localparam int TWO_PI  = 32'sd1647099;

   // Pre-scaled CORDIC gain 1/K so the rotated vector lands on the unit circle
   localparam int K_GAIN  = 32'sd159189;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PREP   = 2'd1,
      ROTATE = 2'd2,
      DONE   = 2'd3
   } state_t;

   // atan(2**-idx) in Q18; entries past 19 are never used and read as zero
   function automatic logic signed [31:0] atan_lut(input logic [4:0] idx);
      logic signed [31:0] val;
      case (idx)
         5'd0:    val = 32'sd205887;
         5'd1:    val = 32'sd121543;
         5'd2:    val = 32'sd64220;
         5'd3:    val = 32'sd32599;
         5'd4:    val = 32'sd16363;
         5'd5:    val = 32'sd8189;
         5'd6:    val = 32'sd4096;
         5'd7:    val = 32'sd2048;
         5'd8:    val = 32'sd1024;
         5'd9:    val = 32'sd512;
         5'd10:   val = 32'sd256;
         5'd11:   val = 32'sd128;
         5'd12:   val = 32'sd64;
         5'd13:   val = 32'sd32;
         5'd14:   val = 32'sd16;
         5'd15:   val = 32'sd8;
         5'd16:   val = 32'sd4;
         5'd17:   val = 32'sd2;
         5'd18:   val = 32'sd1;
         5'd19:   val = 32'sd0;
         default: val = 32'sd0;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/cordic_sincos_if.sv
// Start/valid handshake and result bus of the cordic_sincos block.
// master: the angle source (drives start/theta_in); slave: the converter.
interface cordic_sincos_if #(
   parameter int N = 32
);
   logic                start;
   logic signed [N-1:0] theta_in;
   logic                ready;
   logic                valid;
   logic signed [N-1:0] ctheta;
   logic signed [N-1:0] stheta;

   modport master (
      output start,
      output theta_in,
      input  ready,
      input  valid,
      input  ctheta,
      input  stheta
   );

   modport slave (
      input  start,
      input  theta_in,
      output ready,
      output valid,
      output ctheta,
      output stheta
   );
endinterface

// File: rtl/cordic_stage.sv
// One combinational CORDIC micro-rotation in rotation mode. The rotation
// direction follows the sign of the residual angle z (z >= 0 rotates +1).
// Shifts are arithmetic and truncate toward minus infinity.
module cordic_stage
   import cordic_pkg::*;
#(
   parameter int W = 34
) (
   input  logic signed [W-1:0] x,
   input  logic signed [W-1:0] y,
   input  logic signed [W-1:0] z,
   input  logic        [4:0]   i,
   output logic signed [W-1:0] x_next,
   output logic signed [W-1:0] y_next,
   output logic signed [W-1:0] z_next
);

   logic signed [W-1:0] x_sh_s;
   logic signed [W-1:0] y_sh_s;
   logic signed [W-1:0] atan_s;

   // Shift-and-add rotation by +/- atan(2**-i)
   always_comb begin
      x_sh_s = x >>> i;
      y_sh_s = y >>> i;
      atan_s = W'(atan_lut(i));
      if (z[W-1] == 1'b0) begin
         x_next = x - y_sh_s;
         y_next = y + x_sh_s;
         z_next = z - atan_s;
      end else begin
         x_next = x + y_sh_s;
         y_next = y - x_sh_s;
         z_next = z + atan_s;
      end
   end

endmodule

// File: rtl/cordic_sincos.sv
// Iterative rotation-mode CORDIC producing Q18 cos/sin of a Q18 angle.
// One conversion takes ITER+2 cycles from the accepting edge to the valid
// pulse; the last result is held between conversions.
// Optional build macro: SINCOS_SATURATE_EN clamps both outputs to [-1.0, +1.0].
module cordic_sincos
   import cordic_pkg::*;
#(
   parameter int N    = 32,
   parameter int Q    = 18,
   parameter int ITER = 16
) (
   input logic            clk,
   input logic            reset,
   cordic_sincos_if.slave bus
);

   // Two guard bits absorb the CORDIC gain growth and the unwrapped input range
   localparam int W = N + 2;

   localparam logic signed [W-1:0] PI_W      = W'(PI);
   localparam logic signed [W-1:0] HALF_PI_W = W'(HALF_PI);
   localparam logic signed [W-1:0] TWO_PI_W  = W'(TWO_PI);
   localparam logic signed [W-1:0] K_W       = W'(K_GAIN);
   localparam logic signed [N-1:0] ONE_N     = N'(64'sd1 << Q);
   localparam logic        [4:0]   LAST_I    = 5'(ITER - 1);

   state_t              state_r;
   state_t              next_state_s;

   logic signed [W-1:0] x_r;
   logic signed [W-1:0] y_r;
   logic signed [W-1:0] z_r;
   logic        [4:0]   i_r;
   logic                neg_r;

   logic signed [W-1:0] x_nx_s;
   logic signed [W-1:0] y_nx_s;
   logic signed [W-1:0] z_nx_s;

   logic signed [W-1:0] z_wrap_s;
   logic signed [W-1:0] z_fold_s;
   logic                neg_fold_s;
   logic                accept_s;

   logic signed [N-1:0] cos_s;
   logic signed [N-1:0] sin_s;

   logic                ready_r;
   logic                valid_r;
   logic signed [N-1:0] ctheta_r;
   logic signed [N-1:0] stheta_r;

   // Clamp a Q18 value to the closed unit interval
   function automatic logic signed [N-1:0] clamp_unit(input logic signed [N-1:0] v);
      logic signed [N-1:0] r;
      if (v > ONE_N) begin
         r = ONE_N;
      end else if (v < -ONE_N) begin
         r = -ONE_N;
      end else begin
         r = v;
      end
      return r;
   endfunction

   cordic_stage #(
      .W (W)
   ) u_stage (
      .x      (x_r),
      .y      (y_r),
      .z      (z_r),
      .i      (i_r),
      .x_next (x_nx_s),
      .y_next (y_nx_s),
      .z_next (z_nx_s)
   );

   // A new angle is taken only while the block reports ready (IDLE or DONE)
   always_comb begin
      accept_s = 1'b0;
      if (bus.start && ((state_r == IDLE) || (state_r == DONE))) begin
         accept_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end
   end

   // Range reduction: one 2*pi wrap, then fold into [-pi/2, pi/2] and remember the sign flip
   always_comb begin
      z_wrap_s   = z_r;
      z_fold_s   = z_r;
      neg_fold_s = 1'b0;
      if (z_r > PI_W) begin
         z_wrap_s = z_r - TWO_PI_W;
      end else if (z_r < -PI_W) begin
         z_wrap_s = z_r + TWO_PI_W;
      end else begin
         z_wrap_s = z_r;
      end
      if (z_wrap_s > HALF_PI_W) begin
         z_fold_s   = z_wrap_s - PI_W;
         neg_fold_s = 1'b1;
      end else if (z_wrap_s < -HALF_PI_W) begin
         z_fold_s   = z_wrap_s + PI_W;
         neg_fold_s = 1'b1;
      end else begin
         z_fold_s   = z_wrap_s;
         neg_fold_s = 1'b0;
      end
   end

   // Next-state decode of the conversion sequencer
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               next_state_s = PREP;
            end else begin
               next_state_s = IDLE;
            end
         end
         PREP: begin
            next_state_s = ROTATE;
         end
         ROTATE: begin
            if (i_r == LAST_I) begin
               next_state_s = DONE;
            end else begin
               next_state_s = ROTATE;
            end
         end
         DONE: begin
            if (bus.start) begin
               next_state_s = PREP;
            end else begin
               next_state_s = IDLE;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // x/y/z datapath: capture angle, reduce it, then one micro-rotation per cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         x_r   <= '0;
         y_r   <= '0;
         z_r   <= '0;
         i_r   <= 5'd0;
         neg_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE, DONE: begin
               if (accept_s) begin
                  z_r <= W'(bus.theta_in);
               end else begin
                  z_r <= z_r;
               end
            end
            PREP: begin
               z_r   <= z_fold_s;
               neg_r <= neg_fold_s;
               x_r   <= K_W;
               y_r   <= '0;
               i_r   <= 5'd0;
            end
            ROTATE: begin
               x_r <= x_nx_s;
               y_r <= y_nx_s;
               z_r <= z_nx_s;
               i_r <= i_r + 5'd1;
            end
            default: begin
               z_r <= z_r;
            end
         endcase
      end
   end

   // Undo the quadrant fold and optionally clamp before the output register
   always_comb begin
      cos_s = x_r[N-1:0];
      sin_s = y_r[N-1:0];
      if (neg_r) begin
         cos_s = -x_r[N-1:0];
         sin_s = -y_r[N-1:0];
      end else begin
         cos_s = x_r[N-1:0];
         sin_s = y_r[N-1:0];
      end
`ifdef SINCOS_SATURATE_EN
      cos_s = clamp_unit(cos_s);
      sin_s = clamp_unit(sin_s);
`endif
   end

   // Result registers: updated only on leaving DONE, held otherwise
   always_ff @(posedge clk) begin
      if (reset) begin
         ctheta_r <= ONE_N;
         stheta_r <= '0;
         valid_r  <= 1'b0;
      end else if (state_r == DONE) begin
         ctheta_r <= cos_s;
         stheta_r <= sin_s;
         valid_r  <= 1'b1;
      end else begin
         valid_r  <= 1'b0;
      end
   end

   // ready is registered from the upcoming state so it lines up with state_r
   always_ff @(posedge clk) begin
      if (reset) begin
         ready_r <= 1'b1;
      end else begin
         ready_r <= (next_state_s == IDLE) || (next_state_s == DONE);
      end
   end

   assign bus.ready  = ready_r;
   assign bus.valid  = valid_r;
   assign bus.ctheta = ctheta_r;
   assign bus.stheta = stheta_r;

endmodule

// File: tb/tb_cordic_sincos.sv
// Self-checking bench for cordic_sincos: directed angles, handshake corner
// cases, reset abort and randomized angles against real-valued cos/sin.
// Compile with SINCOS_SATURATE_EN to add the clamp sweep.
module tb_cordic_sincos;

   localparam int N = 32;
   localparam real SCALE = 262144.0;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_pass;

   cordic_sincos_if #(.N(N)) bus ();

   cordic_sincos #(
      .N    (N),
      .Q    (18),
      .ITER (16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: |obs - exp| must be within tol
   task automatic check_val(input string tag, input longint obs, input longint exp, input longint tol);
      longint diff;
      diff = obs - exp;
      if (diff < 0) diff = -diff;
      n_checks++;
      if (diff <= tol) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
      end
   endtask

   // Reference model: exact trig of the Q18 angle, rounded to Q18
   function automatic longint ref_cos(input longint theta);
      return longint'($cos(real'(theta) / SCALE) * SCALE);
   endfunction

   function automatic longint ref_sin(input longint theta);
      return longint'($sin(real'(theta) / SCALE) * SCALE);
   endfunction

   // One isolated conversion; reports latency, result, ready and hold violations
   task automatic convert(input longint theta, output longint c, output longint s,
                          output int lat, output int ready_bad, output int glitch);
      longint prev_c;
      longint prev_s;
      @(negedge clk);
      prev_c = bus.ctheta;
      prev_s = bus.stheta;
      bus.start    = 1'b1;
      bus.theta_in = 32'(theta);
      lat = -1; ready_bad = 0; glitch = 0; c = 0; s = 0;
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
         if (j == 0) begin
            bus.start    = 1'b0;
            bus.theta_in = $urandom;
         end
         if (bus.valid) begin
            lat = j; c = bus.ctheta; s = bus.stheta;
            break;
         end
         if (j <= 16 && bus.ready) ready_bad++;
         if (j == 17 && !bus.ready) ready_bad++;
         if (bus.ctheta != prev_c || bus.stheta != prev_s) glitch++;
      end
      @(negedge clk);
      if (bus.valid) glitch++;
   endtask

   // Directed conversion checked against fixed Q18 expectations
   task automatic directed(input string tag, input longint theta, input longint ec, input longint es);
      longint c, s;
      int lat, rb, gl;
      convert(theta, c, s, lat, rb, gl);
      check_val({tag, "_latency"}, lat, 18, 0);
      check_val({tag, "_cos"}, c, ec, 16);
      check_val({tag, "_sin"}, s, es, 16);
      check_val({tag, "_ready"}, rb, 0, 0);
      check_val({tag, "_hold"}, gl, 0, 0);
   endtask

   initial begin
      longint c1, s1, c2, s2, th;
      int t1, t2, npulse, lat, rb, gl;
      n_checks = 0;
      n_pass   = 0;
      reset        = 1'b1;
      bus.start    = 1'b0;
      bus.theta_in = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_ready", bus.ready, 1, 0);
      check_val("rst_valid", bus.valid, 0, 0);
      check_val("rst_cos", bus.ctheta, 262144, 0);
      check_val("rst_sin", bus.stheta, 0, 0);
      reset = 1'b0;

      directed("zero", 0, 262144, 0);
      directed("half_pi", 411775, 0, 262144);
      directed("four_rad", 1048576, -171341, -198389);
      directed("m3pi4", -617662, -185364, -185364);

      // Back-to-back: start held high, second angle presented after the first accept
      @(negedge clk);
      bus.start = 1'b1; bus.theta_in = 32'sd0;
      t1 = -1; t2 = -1; c1 = 0; s1 = 0; c2 = 0; s2 = 0;
      for (int j = 0; j < 60; j++) begin
         @(negedge clk);
         if (j == 0) bus.theta_in = 32'sd205887;
         if (bus.valid) begin
            if (t1 < 0) begin t1 = j; c1 = bus.ctheta; s1 = bus.stheta; end
            else if (t2 < 0) begin t2 = j; c2 = bus.ctheta; s2 = bus.stheta; end
         end
         if (j == 18) bus.start = 1'b0;
         if (t2 >= 0) break;
      end
      check_val("b2b_first_lat", t1, 18, 0);
      check_val("b2b_spacing", t2 - t1, 18, 0);
      check_val("b2b_cos0", c1, 262144, 16);
      check_val("b2b_sin0", s1, 0, 16);
      check_val("b2b_cos1", c2, 185364, 16);
      check_val("b2b_sin1", s2, 185364, 16);

      // Start while busy must be ignored
      @(negedge clk);
      bus.start = 1'b1; bus.theta_in = 32'sd1048576;
      npulse = 0; c1 = 0; s1 = 0; t1 = -1;
      for (int j = 0; j < 45; j++) begin
         @(negedge clk);
         if (j == 0) bus.start = 1'b0;
         if (j == 4) begin bus.start = 1'b1; bus.theta_in = 32'sd411775; end
         if (j == 5) bus.start = 1'b0;
         if (bus.valid) begin npulse++; t1 = j; c1 = bus.ctheta; s1 = bus.stheta; end
      end
      check_val("busy_pulses", npulse, 1, 0);
      check_val("busy_lat", t1, 18, 0);
      check_val("busy_cos", c1, -171341, 16);
      check_val("busy_sin", s1, -198389, 16);

      // Reset at cycle 10 of a conversion aborts it
      @(negedge clk);
      bus.start = 1'b1; bus.theta_in = 32'sd411775;
      npulse = 0;
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
         if (j == 0) bus.start = 1'b0;
         if (j == 9) reset = 1'b1;
         if (j == 10) begin
            check_val("abort_cos", bus.ctheta, 262144, 0);
            check_val("abort_sin", bus.stheta, 0, 0);
            check_val("abort_ready", bus.ready, 1, 0);
            reset = 1'b0;
         end
         if (bus.valid) npulse++;
      end
      check_val("abort_pulses", npulse, 0, 0);

      // Random angles in |theta| < 3*pi; tolerance covers angle residue plus truncation drift
      for (int k = 0; k < 40; k++) begin
         th = longint'($urandom_range(4940000, 0)) - 64'sd2470000;
         convert(th, c1, s1, lat, rb, gl);
         check_val("rnd_lat", lat, 18, 0);
         check_val("rnd_cos", c1, ref_cos(th), 32);
         check_val("rnd_sin", s1, ref_sin(th), 32);
         check_val("rnd_ready", rb, 0, 0);
      end

`ifdef SINCOS_SATURATE_EN
      // Sweep 0..2pi: no output may exceed 1.0 in magnitude
      t1 = 0;
      for (int k = 0; k < 1024; k++) begin
         th = (64'sd1647099 * k) / 1024;
         convert(th, c1, s1, lat, rb, gl);
         if (c1 > 262144 || c1 < -262144 || s1 > 262144 || s1 < -262144 || lat != 18) t1++;
      end
      check_val("sat_sweep", t1, 0, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cordic_sincos.md
Name: cordic_sincos

Overview:
Iterative rotation-mode CORDIC that converts the rotor angle estimate into Q18 cosine and sine. It sits directly upstream of the Kalman estimator and drives its ctheta/stheta inputs. It is typically fed back from the estimator's theta output, one conversion per sample period. A start/valid handshake is used, and the last result is held between conversions.

Parameters:
N, 32, word width of all signed fixed-point signals
Q, 18, fractional bits (1.0 = 2**18 = 262144)
ITER, 16, CORDIC micro-rotations (valid range 8..20)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a conversion; sampled only when ready=1
theta_in  input  N  signed angle, Q18 radians; legal range |theta_in| < 3*pi
ready  output  1  block can accept start this cycle
valid  output  1  one-cycle pulse: ctheta/stheta updated this cycle
ctheta  output  N  signed cos(theta_in), Q18
stheta  output  N  signed sin(theta_in), Q18

Behaviour:
- Reset: state=IDLE, ready=1, valid=0, ctheta=262144, stheta=0. Internal x/y/z/counter are cleared.
- FSM states: IDLE, PREP, ROTATE, DONE.
- IDLE/DONE to PREP: on start=1. theta_in is registered at that edge (edge 0).
- PREP (edge 1): range reduction.
  - If z > PI, then z -= TWO_PI.
  - Else if z < -PI, then z += TWO_PI.
  - Then fold the quadrant: if z > HALF_PI, z -= PI and set neg=1. If z < -HALF_PI, z += PI and set neg=1.
  - Load x=K_GAIN, y=0, i=0, then go to ROTATE.
- ROTATE (edges 2..ITER+1), one micro-rotation per cycle:
  - d = sign(z); use d=+1 when z>=0.
  - x' = x - d*(y>>>i)
  - y' = y + d*(x>>>i)
  - z' = z - d*ATAN_LUT[i]
  - Shifts are arithmetic and truncate. i increments each cycle. Go to DONE after i=ITER-1.
- DONE (edge ITER+2):
  - ctheta = neg ? -x : x
  - stheta = neg ? -y : y
  - valid=1 for exactly this cycle.
  - Go to IDLE, or straight to PREP if start=1 (back-to-back).
- Latency: valid is asserted ITER+2 cycles after the accepting edge (18 cycles at default). Maximum throughput is one result every ITER+2 cycles.
- ready: 1 in IDLE and DONE, 0 in PREP and ROTATE. start while ready=0 is ignored (not queued).
- Outputs hold their value until the next DONE; they never glitch during ROTATE.
- theta_in changing after the accepting edge has no effect.
- Out-of-range input (|theta| >= 3*pi): only a single wrap is applied. The result is deterministic but undefined in value; no error flag.
- Reset mid-operation: abort immediately and return to the reset values. No valid pulse is produced for the aborted conversion.
- Arithmetic: the x/y/z datapath is N+2 bits internally to absorb CORDIC growth. Outputs are truncated to N bits.

Optional Feature:
SINCOS_SATURATE_EN
- Defined: ctheta and stheta are clamped to [-262144, +262144] in DONE, before the output register.
- Undefined: raw CORDIC magnitude is passed through; overshoot of a few LSB above 1.0 is possible.

Decomposition:
- Package cordic_pkg holds:
  - constants PI=823550, HALF_PI=411775, TWO_PI=1647099, K_GAIN=159189 (Q18);
  - ATAN_LUT[0..19] in Q18 (205887, 121543, 64220, 32599, ...);
  - the FSM state enum.
- One sub-module is natural: cordic_stage, the combinational single micro-rotation (x, y, z, i to x', y', z').

Test Plan:
- theta_in=0, start pulse -> valid exactly 18 cycles later; ctheta=262144±16, stheta=0±16; ready low for cycles 1..17.
- theta_in=411775 (pi/2) -> ctheta=0±16, stheta=262144±16.
- theta_in=1048576 (4.0 rad, wraps) -> ctheta=-171341±16, stheta=-198389±16. theta_in=-617662 (-3pi/4) -> ctheta=-185364±16, stheta=-185364±16.
- Back-to-back: start held high with theta_in=0 then 205887 (pi/4) -> two valid pulses 18 cycles apart; second result is 185364±16 for both outputs.
- start pulsed while busy -> ignored; exactly one valid pulse; result matches the first angle.
- Reset asserted at cycle 10 of a conversion -> next cycle ctheta=262144, stheta=0, ready=1; no valid pulse. With SINCOS_SATURATE_EN, sweep 0..2pi in 1024 steps -> no output magnitude exceeds 262144.
